// File: rtl/gf2m_193_pkg.sv
// Shared types and constants for the sect193 reducer, f(x) = x^193 + x^15 + 1.
package gf2m_193_pkg;
   localparam int M      = 193;
   localparam int PROD_W = 385;
   localparam int F_MID  = 15;
   localparam int EXC_W  = PROD_W - M;

   typedef logic [M-1:0]      elem_t;
   typedef logic [PROD_W-1:0] prod_t;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_FOLD = 2'd1,
      S_DONE = 2'd2
   } state_t;
endpackage

// File: rtl/gf2m_reduce_193_if.sv
// Product-in / result-out handshake bundle of the reducer, plus its busy flag.
interface gf2m_reduce_193_if;
   // Valid/ready on both sides: a transfer happens on a rising edge where valid
   // and ready are both high; valid, once raised, is held with stable data until then.
   logic                  in_valid;
   logic                  in_ready;
   gf2m_193_pkg::prod_t   in_prod;
   logic                  out_valid;
   logic                  out_ready;
   gf2m_193_pkg::elem_t   out_res;
   logic                  busy;

   modport master (
      output in_valid, in_prod, out_ready,
      input  in_ready, out_valid, out_res, busy
   );

   modport slave (
      input  in_valid, in_prod, out_ready,
      output in_ready, out_valid, out_res, busy
   );
endinterface

// File: rtl/gf2m_fold_chunk.sv
// Folds one FOLD_W-bit chunk of the excess bits, selected by k (top chunk first),
// back into lower positions using x^193 = x^15 + 1.
module gf2m_fold_chunk
   import gf2m_193_pkg::*;
#(
   parameter int FOLD_W = 32,
   parameter int CNT_W  = 3
) (
   input  prod_t             r,
   input  logic [CNT_W-1:0]  k,
   output prod_t             r_next
);
   localparam int NUM_FOLDS = EXC_W / FOLD_W;

   prod_t folded [NUM_FOLDS];

   for (genvar j = 0; j < NUM_FOLDS; j++) begin : g_step
      localparam int LO = PROD_W - (j + 1) * FOLD_W;
      logic [FOLD_W-1:0] chunk;
      prod_t             f;

      assign chunk = r[LO +: FOLD_W];

      // Bit i moves to i-178 and i-193; all from the chunk sampled at cycle start.
      always_comb begin
         f = r;
         f[LO +: FOLD_W] = '0;
         f = f ^ (prod_t'(chunk) << (LO - (M - F_MID))) ^ (prod_t'(chunk) << (LO - M));
      end

      assign folded[j] = f;
   end

   always_comb begin
      r_next = r;
      for (int j = 0; j < NUM_FOLDS; j++) begin
         if (k == CNT_W'(j)) r_next = folded[j];
      end
   end
endmodule

// File: rtl/gf2m_reduce_193.sv
// Sequential GF(2^193) reducer: captures a 385-bit product, folds FOLD_W excess
// bits per cycle, then presents the 193-bit remainder until the consumer takes it.
module gf2m_reduce_193
   import gf2m_193_pkg::*;
#(
   parameter int FOLD_W = 32
) (
   input  logic                    clk,
   input  logic                    rst_n,
   gf2m_reduce_193_if.slave        bus,
   output state_t                  state_dbg
);
   localparam int NUM_FOLDS = EXC_W / FOLD_W;
   localparam int CNT_W     = $clog2(NUM_FOLDS);

   if (FOLD_W < 1 || FOLD_W > 96 || (EXC_W % FOLD_W) != 0) begin : g_bad_fold_w
      $error("FOLD_W must divide 192 and lie in 1..96");
   end

   state_t            state, state_n;
   prod_t             r, r_n, r_fold;
   logic [CNT_W-1:0]  cnt, cnt_n;
   logic              in_ready, out_valid, busy;
   elem_t             out_res;

   gf2m_fold_chunk #(
      .FOLD_W (FOLD_W),
      .CNT_W  (CNT_W)
   ) u_fold (
      .r      (r),
      .k      (cnt),
      .r_next (r_fold)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= S_IDLE;
         r     <= '0;
         cnt   <= '0;
      end else begin
         state <= state_n;
         r     <= r_n;
         cnt   <= cnt_n;
      end
   end

   always_comb begin
      state_n   = state;
      r_n       = r;
      cnt_n     = cnt;
      in_ready  = 1'b0;
      out_valid = 1'b0;
      busy      = 1'b0;
      out_res   = '0;
      case (state)
         S_IDLE: begin
            in_ready = 1'b1;
            if (bus.in_valid) begin
               r_n     = bus.in_prod;
               cnt_n   = '0;
               state_n = S_FOLD;
            end
         end
         S_FOLD: begin
            busy  = 1'b1;
            r_n   = r_fold;
            cnt_n = cnt + CNT_W'(1);
            if (cnt == CNT_W'(NUM_FOLDS - 1)) state_n = S_DONE;
         end
         S_DONE: begin
            busy      = 1'b1;
            out_valid = 1'b1;
            out_res   = r[M-1:0];
            if (bus.out_ready) state_n = S_IDLE;
         end
         default: state_n = S_IDLE;
      endcase
   end

   assign bus.in_ready  = in_ready;
   assign bus.out_valid = out_valid;
   assign bus.out_res   = out_res;
   assign bus.busy      = busy;
   assign state_dbg     = state;
endmodule

// File: tb/tb_gf2m_reduce_193.sv
// Directed bench for gf2m_reduce_193: the same stimulus drives FOLD_W = 32, 1 and 96.
module tb_gf2m_reduce_193;
   import gf2m_193_pkg::*;

   typedef struct {
      prod_t prod;
      elem_t exp;
      string name;
   } vec_t;

   logic  clk = 1'b0;
   logic  rst_n;
   logic  in_valid;
   prod_t in_prod;
   logic  out_ready;

   int n_tests = 0;
   int n_fail  = 0;

   gf2m_reduce_193_if b32 ();
   gf2m_reduce_193_if b1 ();
   gf2m_reduce_193_if b96 ();

   state_t st32, st1, st96;

   assign b32.in_valid  = in_valid;
   assign b32.in_prod   = in_prod;
   assign b32.out_ready = out_ready;
   assign b1.in_valid   = in_valid;
   assign b1.in_prod    = in_prod;
   assign b1.out_ready  = out_ready;
   assign b96.in_valid  = in_valid;
   assign b96.in_prod   = in_prod;
   assign b96.out_ready = out_ready;

   gf2m_reduce_193 #(.FOLD_W(32)) dut32 (.clk(clk), .rst_n(rst_n), .bus(b32), .state_dbg(st32));
   gf2m_reduce_193 #(.FOLD_W(1))  dut1  (.clk(clk), .rst_n(rst_n), .bus(b1),  .state_dbg(st1));
   gf2m_reduce_193 #(.FOLD_W(96)) dut96 (.clk(clk), .rst_n(rst_n), .bus(b96), .state_dbg(st96));

   logic [2:0] ov, ir, bz;
   elem_t      res [3];
   int         fw [3]      = '{32, 1, 96};
   int         exp_lat [3] = '{6, 192, 2};

   assign ov     = {b96.out_valid, b1.out_valid, b32.out_valid};
   assign ir     = {b96.in_ready,  b1.in_ready,  b32.in_ready};
   assign bz     = {b96.busy,      b1.busy,      b32.busy};
   assign res[0] = b32.out_res;
   assign res[1] = b1.out_res;
   assign res[2] = b96.out_res;

   always #5 clk = ~clk;

   task automatic check(input string nm, input logic [192:0] got, input logic [192:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", nm, got, exp);
      end
   endtask

   function automatic prod_t junk_prod();
      prod_t v;
      for (int b = 0; b < PROD_W; b++) v[b] = 1'($urandom_range(0, 1));
      return v;
   endfunction

   // One transaction on all three instances; results are held until all are valid.
   task automatic run_txn(input prod_t p, input elem_t e, input string nm, input bit poke);
      int    lat [3] = '{-1, -1, -1};
      int    edges   = 0;
      int    bp_bad  = 0;
      elem_t held;
      @(negedge clk);
      out_ready = 1'b0;
      in_valid  = 1'b1;
      in_prod   = p;
      check({nm, "_in_ready_idle"}, 193'(ir), 193'(3'b111));
      @(posedge clk); #1;
      in_valid = 1'b0;
      in_prod  = junk_prod();
      while ((lat[0] < 0 || lat[1] < 0 || lat[2] < 0) && edges < 400) begin
         @(posedge clk); #1;
         edges++;
         if (edges == 1) begin
            check({nm, "_in_ready_fold"}, 193'(ir), 193'(3'b000));
            check({nm, "_busy_fold"}, 193'(bz), 193'(3'b111));
         end
         if (poke && edges == 2) begin
            in_valid = 1'b1;
            in_prod  = junk_prod();
         end
         if (poke && edges == 4) in_valid = 1'b0;
         if (lat[0] >= 0 && (ov[0] !== 1'b1 || res[0] !== held)) bp_bad++;
         for (int d = 0; d < 3; d++) begin
            if (lat[d] < 0 && ov[d] === 1'b1) lat[d] = edges;
         end
         if (lat[0] == edges) held = res[0];
      end
      in_valid = 1'b0;
      for (int d = 0; d < 3; d++) begin
         check($sformatf("%s_latency_w%0d", nm, fw[d]), 193'(lat[d]), 193'(exp_lat[d]));
         check($sformatf("%s_result_w%0d", nm, fw[d]), res[d], e);
      end
      check({nm, "_backpressure_hold"}, 193'(bp_bad), 193'(0));
      @(negedge clk);
      out_ready = 1'b1;
      @(posedge clk); #1;
      check({nm, "_out_valid_release"}, 193'(ov), 193'(3'b000));
      check({nm, "_in_ready_release"}, 193'(ir), 193'(3'b111));
      @(negedge clk);
      out_ready = 1'b0;
   endtask

   vec_t  vecs [5];
   prod_t p;
   elem_t e;

   initial begin
      rst_n     = 1'b0;
      in_valid  = 1'b0;
      in_prod   = '0;
      out_ready = 1'b0;
      #1;
      check("reset_out_valid", 193'(ov), 193'(3'b000));
      check("reset_in_ready", 193'(ir), 193'(3'b111));
      check("reset_busy", 193'(bz), 193'(3'b000));
      check("reset_out_res", res[0] | res[1] | res[2], '0);
      check("reset_state", 193'(st32), 193'(S_IDLE));
      repeat (2) @(negedge clk);
      rst_n = 1'b1;

      p = '0; p[193] = 1'b1;
      e = '0; e[15] = 1'b1; e[0] = 1'b1;
      vecs[0] = '{prod: p, exp: e, name: "x193"};
      p = '0; p[384] = 1'b1;
      e = '0; e[191] = 1'b1; e[28] = 1'b1; e[13] = 1'b1;
      vecs[1] = '{prod: p, exp: e, name: "x384"};
      p = '0; p[192] = 1'b1;
      e = '0; e[192] = 1'b1;
      vecs[2] = '{prod: p, exp: e, name: "x192_passthru"};
      p = '0; p[193] = 1'b1; p[0] = 1'b1;
      e = '0; e[15] = 1'b1;
      vecs[3] = '{prod: p, exp: e, name: "x193_plus_1"};
      p = '0;
      for (int b = 0; b < M; b++) p[b] = 1'($urandom_range(0, 1));
      vecs[4] = '{prod: p, exp: p[M-1:0], name: "low_random"};

      for (int v = 0; v < 5; v++) run_txn(vecs[v].prod, vecs[v].exp, vecs[v].name, 1'b0);

      // Second in_valid pulse while folding must be ignored.
      p = '0; p[200] = 1'b1; p[0] = 1'b1;
      e = '0; e[22] = 1'b1; e[7] = 1'b1; e[0] = 1'b1;
      run_txn(p, e, "x200_plus_1_poke", 1'b1);

      // Reset asserted during fold step 3 of the FOLD_W=32 instance.
      @(negedge clk);
      in_valid = 1'b1;
      in_prod  = vecs[1].prod;
      @(posedge clk); #1;
      in_valid = 1'b0;
      repeat (3) begin
         @(posedge clk); #1;
      end
      check("midrst_pre_w96_valid", 193'(ov[2]), 193'(1'b1));
      #2;
      rst_n = 1'b0;
      #1;
      check("midrst_out_valid", 193'(ov), 193'(3'b000));
      check("midrst_in_ready", 193'(ir), 193'(3'b111));
      check("midrst_busy", 193'(bz), 193'(3'b000));
      check("midrst_out_res", res[0] | res[1] | res[2], '0);
      @(negedge clk);
      rst_n = 1'b1;
      run_txn(vecs[0].prod, vecs[0].exp, "x193_after_reset", 1'b0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
